router_mport: RTL

ROUTER_MPORT -- requirements
Module: router_mport

---
 rtl/router_pkg.sv | 29 ++
 rtl/router_pkt_buf.sv | 21 ++
 rtl/router_mport.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the multi-port packet router.
package router_pkg;

   typedef enum logic [3:0] {
      ERR_NONE  = 4'd0,
      ERR_BUSY  = 4'd1,
      ERR_CRC   = 4'd2,
      ERR_SHORT = 4'd3,
      ERR_LONG  = 4'd4,
      ERR_LEN   = 4'd5,
      ERR_DEST  = 4'd6
   } err_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_CHECK,
      ST_SEND
   } state_e;

   localparam logic [31:0] OFF_DA      = 32'd1;
   localparam logic [31:0] OFF_LEN     = 32'd2;
   localparam logic [31:0] OFF_CRC     = 32'd6;
   localparam logic [31:0] OFF_PAYLOAD = 32'd10;

   localparam int DEF_MIN_PKT_LEN = 12;
   localparam int DEF_MAX_PKT_LEN = 2000;

endpackage

// File: rtl/router_pkt_buf.sv
// Packet byte buffer: one write port, one registered read port.
module router_pkt_buf #(
   parameter int DEPTH = 2000,
   parameter int AW    = 11
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/router_mport.sv
// Store-and-forward packet router: receive, check, forward to port da.
// Optional statistics counters are enabled by defining ROUTER_STATS_EN.
module router_mport
   import router_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
   parameter int MIN_PKT_LEN = DEF_MIN_PKT_LEN
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             dut_inp,
   input  logic                   inp_valid,
   output logic [8*NUM_PORTS-1:0] dut_outp,
   output logic [NUM_PORTS-1:0]   outp_valid,
   input  logic [NUM_PORTS-1:0]   outp_ready,
   output logic                   busy,
   output logic [3:0]             error
);

   localparam int          AW      = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
   localparam logic [31:0] MAX_L   = 32'(MAX_PKT_LEN);
   localparam logic [31:0] MIN_L   = 32'(MIN_PKT_LEN);
   localparam logic [31:0] PORTS_L = 32'(NUM_PORTS);

   state_e        state, state_nxt;
   err_e          err_q, code;
   logic [31:0]   count, len_q, crc_q, crc_acc, idx, pos;
   logic [7:0]    da_q, rd_data;
   logic          cap, xfer, last, wr_en;
   logic [AW-1:0] rd_addr;

   assign cap   = inp_valid && (state == ST_IDLE || state == ST_RECV);
   assign pos   = (state == ST_IDLE) ? '0 : count;
   assign wr_en = cap && (pos < MAX_L);
   assign last  = (idx == len_q - 32'd1);
   assign error = err_q;

   router_pkt_buf #(.DEPTH(MAX_PKT_LEN), .AW(AW)) u_buf (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (pos[AW-1:0]),
      .wr_data (dut_inp),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt  = state;
      code       = ERR_NONE;
      rd_addr    = '0;
      outp_valid = '0;
      dut_outp   = '0;
      busy       = 1'b0;
      if (count != len_q)                code = ERR_LEN;
      else if (count < MIN_L)            code = ERR_SHORT;
      else if (count > MAX_L)            code = ERR_LONG;
      else if ({24'd0, da_q} >= PORTS_L) code = ERR_DEST;
      else if (crc_acc != crc_q)         code = ERR_CRC;
      if (state == ST_SEND) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (da_q == 8'(p)) begin
               outp_valid[p]     = 1'b1;
               dut_outp[8*p +: 8] = rd_data;
            end
         end
      end
      xfer = |(outp_valid & outp_ready);
      case (state)
         ST_IDLE:  if (inp_valid) state_nxt = ST_RECV;
         ST_RECV:  if (!inp_valid) state_nxt = ST_CHECK;
         ST_CHECK: begin
            busy      = 1'b1;
            state_nxt = (code == ERR_NONE) ? ST_SEND : ST_IDLE;
         end
         ST_SEND: begin
            busy = 1'b1;
            // Read one byte ahead on a transfer so the next byte is ready the following cycle.
            rd_addr = (xfer && !last) ? AW'(idx + 32'd1) : idx[AW-1:0];
            if (xfer && last) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         err_q   <= ERR_NONE;
         count   <= '0;
         len_q   <= '0;
         crc_q   <= '0;
         crc_acc <= '0;
         idx     <= '0;
         da_q    <= '0;
      end else begin
         state <= state_nxt;
         if (cap) begin
            count <= pos + 32'd1;
            if (state == ST_IDLE) begin
               len_q   <= '0;
               crc_q   <= '0;
               crc_acc <= '0;
               da_q    <= '0;
               err_q   <= ERR_NONE;
            end
            if (pos == OFF_DA) da_q <= dut_inp;
            if (pos >= OFF_LEN && pos < OFF_CRC) len_q <= {dut_inp, len_q[31:8]};
            if (pos >= OFF_CRC && pos < OFF_PAYLOAD) crc_q <= {dut_inp, crc_q[31:8]};
            if (pos >= OFF_PAYLOAD) crc_acc <= crc_acc + {24'd0, dut_inp};
         end
         if (state == ST_CHECK) begin
            err_q <= inp_valid ? ERR_BUSY : code;
            idx   <= '0;
         end
         if (state == ST_SEND) begin
            if (inp_valid) err_q <= ERR_BUSY;
            if (xfer) idx <= idx + 32'd1;
         end
         if (state != ST_IDLE && state_nxt == ST_IDLE) count <= '0;
      end
   end

`ifdef ROUTER_STATS_EN
   logic [31:0] total_inp_pkt_count, total_outp_pkt_count, crc_dropped_count;
   logic [31:0] len_dropped_count, corrupt_dropped_count, dest_dropped_count;
   logic [31:0] out_pkt_count [NUM_PORTS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         total_inp_pkt_count   <= '0;
         total_outp_pkt_count  <= '0;
         crc_dropped_count     <= '0;
         len_dropped_count     <= '0;
         corrupt_dropped_count <= '0;
         dest_dropped_count    <= '0;
         for (int unsigned p = 0; p < NUM_PORTS; p++) out_pkt_count[p] <= '0;
      end else begin
         if (cap && state == ST_IDLE) total_inp_pkt_count <= total_inp_pkt_count + 32'd1;
         if (state == ST_CHECK) begin
            case (code)
               ERR_CRC:            crc_dropped_count     <= crc_dropped_count + 32'd1;
               ERR_SHORT, ERR_LONG: len_dropped_count    <= len_dropped_count + 32'd1;
               ERR_LEN:            corrupt_dropped_count <= corrupt_dropped_count + 32'd1;
               ERR_DEST:           dest_dropped_count    <= dest_dropped_count + 32'd1;
               default: ;
            endcase
         end
         if (state == ST_SEND && xfer && last) begin
            total_outp_pkt_count <= total_outp_pkt_count + 32'd1;
            for (int unsigned p = 0; p < NUM_PORTS; p++)
               if (da_q == 8'(p)) out_pkt_count[p] <= out_pkt_count[p] + 32'd1;
         end
      end
   end
`else
   // statistics counters compiled out
`endif

endmodule
